axi_wr_router: RTL and testbench

// - Parametrised AXI4 write-burst router: accepts one write burst at a time on an AXI4 slave port.
// - Decodes the target from the top address bits; forwards every beat to one of NUM_TGT

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_wr_router_if.sv | 42 ++++
 rtl/axi_burst_addr_gen.sv | 43 ++++
 rtl/axi_wr_router.sv | 158 +++++++++++++++
 tb/tb_axi_wr_router.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared types for the AXI4 write-burst router: burst kinds, response codes, FSM states.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DRAIN,
        ST_RESP
    } state_e;

endpackage

// File: rtl/axi_wr_router_if.sv
// AXI4 write channels (AW/W/B) seen by the router; the router takes the slave modport.
interface axi_wr_router_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     s_axi_awid;
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic [7:0]              s_axi_awlen;
    logic [2:0]              s_axi_awsize;
    logic [1:0]              s_axi_awburst;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wlast;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [ID_WIDTH-1:0]     s_axi_bid;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;

    modport slave (
        input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bid, s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready
    );

    modport master (
        output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
        output s_axi_bready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Per-burst word address and beat counter; last flags the beat whose count equals awlen.
module axi_burst_addr_gen #(
    parameter int LOCAL_AW = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [LOCAL_AW-1:0] load_addr,
    input  logic [7:0]          load_len,
    input  logic                load_incr,
    input  logic                advance,
    output logic [LOCAL_AW-1:0] word_addr,
    output logic                last
);
    logic [LOCAL_AW-1:0] addr_q;
    logic [7:0]          cnt_q;
    logic [7:0]          len_q;
    logic                incr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
            incr_q <= 1'b0;
        end else if (load) begin
            addr_q <= load_addr;
            cnt_q  <= '0;
            len_q  <= load_len;
            incr_q <= load_incr;
        end else if (advance) begin
            cnt_q <= cnt_q + 8'd1;
            // Natural overflow gives the mod 2**LOCAL_AW wrap
            if (incr_q) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign word_addr = addr_q;
    assign last      = (cnt_q == len_q);

endmodule

// File: rtl/axi_wr_router.sv
// AXI4 write-burst router: decodes the target from the top address bits and forwards
// each beat to one valid/ready target port; malformed bursts are drained with SLVERR.
module axi_wr_router
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int NUM_TGT    = 4,
    parameter int SEL_W      = 2,
    parameter int LOCAL_AW   = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    axi_wr_router_if.slave                 s_axi,
    output logic [NUM_TGT*DATA_WIDTH-1:0]   tgt_wdata,
    output logic [NUM_TGT*DATA_WIDTH/8-1:0] tgt_wstrb,
    output logic [NUM_TGT*LOCAL_AW-1:0]     tgt_waddr,
    output logic [NUM_TGT-1:0]              tgt_wlast,
    output logic [NUM_TGT-1:0]              tgt_wvalid,
    input  logic [NUM_TGT-1:0]              tgt_wready,
    output logic [31:0]                     beats_written,
    output logic [15:0]                     err_count
);
    localparam int B = $clog2(DATA_WIDTH/8);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [ID_WIDTH-1:0] id_q;
    logic                bad_q;
    logic [1:0]          bresp_q;
    logic [31:0]         beats_q;
    logic [15:0]         errs_q;

    logic [SEL_W-1:0]    aw_sel;
    logic                aw_bad;
    logic [NUM_TGT-1:0]  sel_hot;
    logic                aw_fire, beat_fire, burst_done;
    logic                awready, wready, bvalid;
    logic [LOCAL_AW-1:0] word_addr;
    logic                beat_last;
    logic                unused_addr;

    assign aw_sel      = s_axi.s_axi_awaddr[ADDR_WIDTH-1 -: SEL_W];
    assign unused_addr = ^s_axi.s_axi_awaddr;

    always_comb begin
        aw_bad = ({{(32-SEL_W){1'b0}}, aw_sel} >= 32'(NUM_TGT))
              || ((s_axi.s_axi_awburst != BURST_FIXED) && (s_axi.s_axi_awburst != BURST_INCR))
              || (s_axi.s_axi_awsize != 3'(B));
    end

    always_comb begin
        sel_hot = '0;
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
            sel_hot[i] = (sel_q == SEL_W'(i));
        end
    end

    axi_burst_addr_gen #(
        .LOCAL_AW (LOCAL_AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (aw_fire),
        .load_addr (s_axi.s_axi_awaddr[LOCAL_AW+B-1:B]),
        .load_len  (s_axi.s_axi_awlen),
        .load_incr (s_axi.s_axi_awburst == BURST_INCR),
        .advance   (beat_fire),
        .word_addr (word_addr),
        .last      (beat_last)
    );

    always_comb begin
        state_d    = state_q;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        tgt_wvalid = '0;
        tgt_wlast  = '0;
        aw_fire    = 1'b0;
        beat_fire  = 1'b0;
        burst_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                awready = 1'b1;
                if (s_axi.s_axi_awvalid) begin
                    aw_fire = 1'b1;
                    state_d = aw_bad ? ST_DRAIN : ST_DATA;
                end
            end
            ST_DATA: begin
                wready     = |(tgt_wready & sel_hot);
                tgt_wvalid = sel_hot & {NUM_TGT{s_axi.s_axi_wvalid}};
                tgt_wlast  = sel_hot & {NUM_TGT{beat_last}};
                beat_fire  = s_axi.s_axi_wvalid && wready;
            end
            ST_DRAIN: begin
                wready    = 1'b1;
                beat_fire = s_axi.s_axi_wvalid;
            end
            ST_RESP: begin
                bvalid = 1'b1;
                if (s_axi.s_axi_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Whichever of wlast or the length count arrives first closes the burst
        if (beat_fire && (s_axi.s_axi_wlast || beat_last)) begin
            burst_done = 1'b1;
            state_d    = ST_RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            id_q    <= '0;
            bad_q   <= 1'b0;
            bresp_q <= RESP_OKAY;
            beats_q <= '0;
            errs_q  <= '0;
        end else begin
            state_q <= state_d;
            if (aw_fire) begin
                sel_q <= aw_sel;
                id_q  <= s_axi.s_axi_awid;
                bad_q <= aw_bad;
            end
            if (burst_done) begin
                bresp_q <= (bad_q || (s_axi.s_axi_wlast != beat_last)) ? RESP_SLVERR : RESP_OKAY;
            end
            if (beat_fire && (state_q == ST_DATA)) begin
                beats_q <= beats_q + 32'd1;
            end
            if ((state_q == ST_RESP) && s_axi.s_axi_bready && (bresp_q == RESP_SLVERR)
                && (errs_q != 16'hFFFF)) begin
                errs_q <= errs_q + 16'd1;
            end
        end
    end

    assign s_axi.s_axi_awready = awready;
    assign s_axi.s_axi_wready  = wready;
    assign s_axi.s_axi_bvalid  = bvalid;
    assign s_axi.s_axi_bid     = id_q;
    assign s_axi.s_axi_bresp   = bresp_q;

    assign tgt_wdata     = {NUM_TGT{s_axi.s_axi_wdata}};
    assign tgt_wstrb     = {NUM_TGT{s_axi.s_axi_wstrb}};
    assign tgt_waddr     = {NUM_TGT{word_addr}};
    assign beats_written = beats_q;
    assign err_count     = errs_q;

endmodule

// File: tb/tb_axi_wr_router.sv
// Self-checking bench for axi_wr_router with three targets: directed vector table,
// a mid-burst reset sequence and randomized bursts against a burst-level model.
module tb_axi_wr_router;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int IW  = 4;
    localparam int NT  = 3;
    localparam int LAW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NT*DW-1:0]   tgt_wdata;
    logic [NT*DW/8-1:0] tgt_wstrb;
    logic [NT*LAW-1:0]  tgt_waddr;
    logic [NT-1:0]      tgt_wlast;
    logic [NT-1:0]      tgt_wvalid;
    logic [NT-1:0]      tgt_wready = '0;
    logic [31:0]        beats_written;
    logic [15:0]        err_count;

    int n_chk = 0;
    int n_err = 0;
    longint exp_bw = 0;
    int exp_ec = 0;

    always #5 clk = ~clk;

    axi_wr_router_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    axi_wr_router #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .NUM_TGT    (NT),
        .SEL_W      (2),
        .LOCAL_AW   (LAW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi         (bus.slave),
        .tgt_wdata     (tgt_wdata),
        .tgt_wstrb     (tgt_wstrb),
        .tgt_waddr     (tgt_waddr),
        .tgt_wlast     (tgt_wlast),
        .tgt_wvalid    (tgt_wvalid),
        .tgt_wready    (tgt_wready),
        .beats_written (beats_written),
        .err_count     (err_count)
    );

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        int unsigned wl;
        int unsigned rmode;
        logic [1:0]  exp_resp;
        int unsigned exp_wr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Burst-level reference: response code and number of beats reaching a target.
    function automatic void predict(input logic [31:0] addr, input logic [7:0] len,
                                    input logic [1:0] burst, input logic [2:0] size,
                                    input int unsigned wl,
                                    output logic [1:0] resp, output int unsigned wr);
        bit good;
        int unsigned nb;
        good = (addr[31:30] < NT) && (burst < 2) && (size == 3);
        nb   = ((wl < len) ? wl : len) + 1;
        resp = (good && (wl == len)) ? 2'b00 : 2'b10;
        wr   = good ? nb : 0;
    endfunction

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int unsigned wl,
                             input int unsigned rmode, input logic [1:0] exp_resp,
                             input int unsigned exp_wr);
        int unsigned sel, base, nb, k, cyc, dly;
        bit good, acc;
        logic [63:0] d;
        sel  = addr[31:30];
        good = (sel < NT) && (burst < 2) && (size == 3);
        base = addr[12:3];
        nb   = ((wl < len) ? wl : len) + 1;

        bus.s_axi_awid    = id;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = len;
        bus.s_axi_awsize  = size;
        bus.s_axi_awburst = burst;
        bus.s_axi_awvalid = 1'b1;
        #1;
        chk("aw_awready", bus.s_axi_awready, 1);
        step();
        bus.s_axi_awvalid = 1'b0;

        k = 0;
        cyc = 0;
        while (k < nb && cyc < 400) begin
            d = {$urandom, $urandom};
            bus.s_axi_wvalid = 1'b1;
            bus.s_axi_wdata  = d;
            bus.s_axi_wstrb  = 8'($urandom);
            bus.s_axi_wlast  = (k == wl);
            case (rmode)
                0: tgt_wready = '1;
                1: tgt_wready = (cyc % 2 == 0) ? '1 : '0;
                default: tgt_wready = 3'($urandom);
            endcase
            #1;
            acc = good ? tgt_wready[sel] : 1'b1;
            if (good) begin
                chk("beat_tvalid", tgt_wvalid, 64'(1) << sel);
                chk("beat_wready", bus.s_axi_wready, acc);
                chk("beat_waddr", tgt_waddr[sel*LAW +: LAW],
                    (burst == 1) ? (base + k) % 1024 : base);
                chk("beat_tlast", tgt_wlast[sel], k == len);
                chk("beat_wdata", tgt_wdata[sel*DW +: DW], d);
                chk("beat_wstrb", tgt_wstrb[sel*8 +: 8], bus.s_axi_wstrb);
            end else begin
                chk("drain_tvalid", tgt_wvalid, 0);
                chk("drain_wready", bus.s_axi_wready, 1);
            end
            step();
            if (acc) k++;
            cyc++;
        end
        if (k < nb) begin
            n_chk++;
            n_err++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", k, nb);
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
        tgt_wready       = '0;
        bus.s_axi_bready = 1'b0;
        #1;
        dly = $urandom_range(0, 2);
        for (int unsigned i = 0; i <= dly; i++) begin
            chk("resp_bvalid", bus.s_axi_bvalid, 1);
            chk("resp_bid", bus.s_axi_bid, id);
            chk("resp_bresp", bus.s_axi_bresp, exp_resp);
            chk("resp_awready", bus.s_axi_awready, 0);
            if (i < dly) begin
                @(posedge clk);
                #2;
            end
        end
        bus.s_axi_bready = 1'b1;
        step();
        bus.s_axi_bready = 1'b0;
        #1;
        chk("post_bvalid", bus.s_axi_bvalid, 0);
        chk("post_awready", bus.s_axi_awready, 1);
        exp_bw += exp_wr;
        if (exp_resp == 2'b10) exp_ec++;
        chk("beats_written", beats_written, 64'(exp_bw % 64'h1_0000_0000));
        chk("err_count", err_count, exp_ec);
    endtask

    initial begin
        logic [1:0] r_resp;
        int unsigned r_wr, r_wl;
        logic [31:0] r_addr;
        logic [7:0]  r_len;
        logic [1:0]  r_burst;
        logic [2:0]  r_size;

        vecs[0] = '{4'h5, 32'h4000_0010, 8'd3, 2'd1, 3'd3, 3, 0, 2'b00, 4};
        vecs[1] = '{4'h2, 32'h0000_0038, 8'd2, 2'd0, 3'd3, 2, 1, 2'b00, 3};
        vecs[2] = '{4'h7, 32'hC000_0000, 8'd1, 2'd1, 3'd3, 1, 0, 2'b10, 0};
        vecs[3] = '{4'h1, 32'h0000_1FF8, 8'd1, 2'd1, 3'd3, 1, 0, 2'b00, 2};
        vecs[4] = '{4'h3, 32'h8000_0000, 8'd3, 2'd1, 3'd3, 0, 0, 2'b10, 1};
        vecs[5] = '{4'hA, 32'h4000_0100, 8'd1, 2'd1, 3'd3, 5, 0, 2'b10, 2};
        vecs[6] = '{4'hB, 32'h0000_0000, 8'd1, 2'd2, 3'd3, 1, 0, 2'b10, 0};
        vecs[7] = '{4'hC, 32'h0000_0000, 8'd1, 2'd1, 3'd2, 1, 0, 2'b10, 0};

        bus.s_axi_awid = '0;    bus.s_axi_awaddr = '0;  bus.s_axi_awlen = '0;
        bus.s_axi_awsize = '0;  bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = '0;   bus.s_axi_wstrb = '0;   bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0;

        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_awready", bus.s_axi_awready, 1);
        chk("rst_wready", bus.s_axi_wready, 0);
        chk("rst_bvalid", bus.s_axi_bvalid, 0);
        chk("rst_bresp", bus.s_axi_bresp, 0);
        chk("rst_bid", bus.s_axi_bid, 0);
        chk("rst_tvalid", tgt_wvalid, 0);
        chk("rst_beats", beats_written, 0);
        chk("rst_errs", err_count, 0);

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].size,
                      vecs[i].wl, vecs[i].rmode, vecs[i].exp_resp, vecs[i].exp_wr);
        end

        // Reset in the middle of a burst after two beats
        bus.s_axi_awid = 4'h9; bus.s_axi_awaddr = 32'h8000_0000; bus.s_axi_awlen = 8'd3;
        bus.s_axi_awsize = 3'd3; bus.s_axi_awburst = 2'd1; bus.s_axi_awvalid = 1'b1;
        step();
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid = 1'b1;
        bus.s_axi_wlast = 1'b0;
        tgt_wready = '1;
        step();
        step();
        chk("mid_beats", beats_written, 64'(exp_bw + 2));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_awready", bus.s_axi_awready, 1);
        chk("mid_rst_wready", bus.s_axi_wready, 0);
        chk("mid_rst_tvalid", tgt_wvalid, 0);
        chk("mid_rst_bvalid", bus.s_axi_bvalid, 0);
        chk("mid_rst_beats", beats_written, 0);
        chk("mid_rst_errs", err_count, 0);
        bus.s_axi_wvalid = 1'b0;
        tgt_wready = '0;
        exp_bw = 0;
        exp_ec = 0;
        run_burst(vecs[0].id, vecs[0].addr, vecs[0].len, vecs[0].burst, vecs[0].size,
                  vecs[0].wl, vecs[0].rmode, vecs[0].exp_resp, vecs[0].exp_wr);

        for (int n = 0; n < 24; n++) begin
            r_addr  = {2'($urandom_range(0, 3)), 17'($urandom), 10'($urandom), 3'b000};
            r_len   = 8'($urandom_range(0, 5));
            r_burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            r_size  = ($urandom_range(0, 5) == 0) ? 3'd2 : 3'd3;
            r_wl    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : int'(r_len);
            predict(r_addr, r_len, r_burst, r_size, r_wl, r_resp, r_wr);
            run_burst(4'($urandom), r_addr, r_len, r_burst, r_size, r_wl, 2, r_resp, r_wr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
